iterative_alu: RTL
==================

Name: iterative_alu

Overview:
- 64-bit execute-stage ALU, directly downstream of the ALU control decoder.
- Consumes the 4-bit Operation code and two operands, then returns a registered result with branch flags through a start/done handshake.
- AND, OR, ADD and SUB complete in one cycle. SLL uses a 1-bit-per-cycle iterative shifter, so latency depends on the shift amount.
- The branch unit reads the flags for BEQ, BNE, BLT and BGE.

Parameters:
- WIDTH, 64, operand and result width.
- SHAMT_W, 6, shift-amount width; shift amount is b[SHAMT_W-1:0].

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, request; sampled on a rising edge only when busy=0.
- Operation, input, 4, 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLL; every other code is illegal.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- busy, output, 1, high while an SLL iteration is in progress.
- done, output, 1, one-cycle pulse; result and flags are valid from this cycle.
- result, output, WIDTH, registered result; held until the next done.
- zero, output, 1, result==0.
- lt, output, 1, signed a<b; valid for SUB only, 0 otherwise.
- illegal, output, 1, last completed op had an illegal code.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; busy, done, result, zero, lt, illegal all 0; shift accumulator and counter 0. Reset mid-SLL aborts the operation and no done is produced.
- States: IDLE, SHIFT. busy = (state==SHIFT), decoded from registered state only.
- IDLE with start=1: Operation, a and b are captured at that edge. Later input changes have no effect on the operation.
- AND/OR/ADD/SUB: result, zero and lt are registered at the accepting edge. done=1 in the following cycle, so latency is 1 and state stays IDLE.
- ADD and SUB wrap modulo 2^WIDTH; no carry or overflow outputs.
- lt is computed from sign and overflow: lt = diff[MSB] XOR overflow, where overflow is the signed overflow of a-b.
- SLL with shamt=0: result=a and latency 1, same as the single-cycle ops.
- SLL with shamt=N>0: at the accepting edge, acc=a, cnt=N, state goes to SHIFT.
- Each SHIFT cycle: acc <= acc<<1 and cnt <= cnt-1.
- When cnt reaches 1 at an edge: result=acc<<1, state goes to IDLE, done=1 next cycle. Latency is N+1 cycles.
- Illegal code: result=0, zero=1, lt=0, illegal=1. Latency 1, state stays IDLE.
- illegal is cleared on the next legal completion.
- start while busy=1 is ignored entirely; it is not queued.
- start in the same cycle as done (state IDLE) is accepted. Single-cycle ops sustain one result per cycle.
- zero, lt and illegal update only together with result, at the edge that raises done; otherwise they hold.
- done is high for exactly one cycle per accepted op.

Test Plan:
- ADD: a=5, b=7 -> done one cycle after start; result=12, zero=0, lt=0.
- SUB: a=9, b=9 -> result=0, zero=1, lt=0.
- SUB signed compare:
  - a=-3, b=2 -> lt=1, result=0xFFFF_FFFF_FFFF_FFFB.
  - a=0x8000_0000_0000_0000, b=1 -> lt=1 (overflow case).
- SLL: a=1, b=5 -> busy high for 5 cycles, done 6 cycles after start, result=32.
- SLL with b=0 -> latency 1, result=a.
- SLL with b=63 -> result=0x8000_0000_0000_0000 after 64 cycles.
- start with ADD pulsed during an SLL busy window -> ignored; only the SLL done/result appears.
- reset_n=0 mid-shift -> outputs immediately 0; no done after release.
- Back-to-back AND then OR on consecutive cycles -> done on two consecutive cycles with the correct results.
- Illegal code Operation=1111 -> illegal=1, result=0, zero=1.
- Subsequent ADD after the illegal op -> illegal=0.

Source files
------------

// File: rtl/iterative_alu.sv
// 64-bit execute-stage ALU: single-cycle AND/OR/ADD/SUB, bit-serial SLL,
// registered result and branch flags behind a start/done handshake.
module iterative_alu #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             lt,
  output logic             illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               zero_q, zero_d;
  logic               lt_q, lt_d;
  logic               illegal_q, illegal_d;

  logic [WIDTH-1:0]   diff;
  logic               sub_ovf;
  logic [SHAMT_W-1:0] shamt;

  assign diff  = a - b;
  // Signed overflow of a-b: operands differ in sign and the result sign flips away from a.
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    zero_d    = zero_q;
    lt_d      = lt_q;
    illegal_d = illegal_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          done_d    = 1'b1;
          lt_d      = 1'b0;
          illegal_d = 1'b0;
          case (Operation)
            OP_AND: result_d = a & b;
            OP_OR:  result_d = a | b;
            OP_ADD: result_d = a + b;
            OP_SUB: begin
              result_d = diff;
              lt_d     = diff[WIDTH-1] ^ sub_ovf;
            end
            OP_SLL: begin
              if (shamt == '0) begin
                result_d = a;
              end else begin
                // Multi-cycle path: flags and result hold until the final shift.
                done_d    = 1'b0;
                lt_d      = lt_q;
                illegal_d = illegal_q;
                acc_d     = a;
                cnt_d     = shamt;
                state_d   = SHIFT;
              end
            end
            default: begin
              result_d  = '0;
              illegal_d = 1'b1;
            end
          endcase
          if (done_d) zero_d = (result_d == '0);
        end
      end
      SHIFT: begin
        acc_d = acc_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          result_d  = acc_q << 1;
          zero_d    = ((acc_q << 1) == '0);
          lt_d      = 1'b0;
          illegal_d = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
      lt_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      zero_q    <= zero_d;
      lt_q      <= lt_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = done_q;
  assign result  = result_q;
  assign zero    = zero_q;
  assign lt      = lt_q;
  assign illegal = illegal_q;

endmodule
